// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
package mem_req_arbiter_pkg;

    localparam int unsigned STARVE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_ZERO = '0;

    function automatic logic req_is_write(input mem_req_t r);
        return (r.strobe != 8'h00);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester, response and shared memory-port signals of the arbiter.
interface mem_req_arbiter_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic [2:0]  ireq_size;
    logic        iresp_ok;
    logic [63:0] iresp_data;
    logic        i_wait;

    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_ok;
    logic [63:0] dresp_data;
    logic        d_wait;

    logic        creq_valid;
    logic        creq_is_write;
    logic [63:0] creq_addr;
    logic [2:0]  creq_size;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready;
    logic [63:0] cresp_data;

    modport slave (
        input  ireq_valid, ireq_addr, ireq_size,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  cresp_ready, cresp_data,
        output iresp_ok, iresp_data, i_wait,
        output dresp_ok, dresp_data, d_wait,
        output creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data
    );

    modport master (
        output ireq_valid, ireq_addr, ireq_size,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output cresp_ready, cresp_data,
        input  iresp_ok, iresp_data, i_wait,
        input  dresp_ok, dresp_data, d_wait,
        input  creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data
    );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch (I) and data (D) requesters, with an I-starvation counter.
module mem_arb_grant
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic idle,
    input  logic ireq_valid,
    input  logic dreq_valid,
    output logic grant_i_s,
    output logic grant_d_s
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                starved_s;

    // D wins ties until I has watched STARVE_MAX consecutive D grants.
    always_comb begin
        starved_s = (starve_cnt_q == STARVE_LIM);
        grant_d_s = idle & dreq_valid & ~(ireq_valid & starved_s);
        grant_i_s = idle & ireq_valid & ~grant_d_s;
        if (!ireq_valid || grant_i_s) begin
            starve_cnt_d = {STARVE_W{1'b0}};
        end else if (grant_d_s && !starved_s) begin
            starve_cnt_d = starve_cnt_q + {{(STARVE_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= {STARVE_W{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter onto a single-beat shared memory port; one transaction in flight.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mem_req_arbiter_if.slave  bus
);

    arb_state_e state_q, state_d;
    mem_req_t   req_q, req_d;
    logic       drop_q, drop_d;
    logic       grant_i_s, grant_d_s;
    logic       owner_valid_s;
    logic       cpl_i_s, cpl_d_s, iok_s, dok_s;

    mem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
        .clk        (clk),
        .resetn     (resetn),
        .idle       (state_q == ST_IDLE),
        .ireq_valid (bus.ireq_valid),
        .dreq_valid (bus.dreq_valid),
        .grant_i_s  (grant_i_s),
        .grant_d_s  (grant_d_s)
    );

    // Next state, request capture and flush tracking of the owning requester.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        drop_d        = drop_q;
        owner_valid_s = (state_q == ST_BUSY_I) ? bus.ireq_valid : bus.dreq_valid;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (grant_d_s) begin
                    state_d     = ST_BUSY_D;
                    req_d.addr   = bus.dreq_addr;
                    req_d.size   = bus.dreq_size;
                    req_d.strobe = bus.dreq_strobe;
                    req_d.data   = bus.dreq_data;
                end else if (grant_i_s) begin
                    state_d     = ST_BUSY_I;
                    req_d.addr   = bus.ireq_addr;
                    req_d.size   = bus.ireq_size;
                    req_d.strobe = 8'h00;
                    req_d.data   = 64'h0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.cresp_ready) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end else if (!owner_valid_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // FSM, request register and drop flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            req_q   <= MEM_REQ_ZERO;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    // Completion is forwarded in the same cycle; a flushed requester gets no ok.
    always_comb begin
        cpl_i_s = (state_q == ST_BUSY_I) & bus.cresp_ready;
        cpl_d_s = (state_q == ST_BUSY_D) & bus.cresp_ready;
        iok_s   = cpl_i_s & ~drop_q & bus.ireq_valid;
        dok_s   = cpl_d_s & ~drop_q & bus.dreq_valid;

        bus.creq_valid    = (state_q != ST_IDLE);
        bus.creq_is_write = req_is_write(req_q);
        bus.creq_addr     = req_q.addr;
        bus.creq_size     = req_q.size;
        bus.creq_strobe   = req_q.strobe;
        bus.creq_data     = req_q.data;

        bus.iresp_ok   = iok_s;
        bus.iresp_data = cpl_i_s ? bus.cresp_data : 64'h0;
        bus.i_wait     = bus.ireq_valid & ~iok_s;
        bus.dresp_ok   = dok_s;
        bus.dresp_data = cpl_d_s ? bus.cresp_data : 64'h0;
        bus.d_wait     = bus.dreq_valid & ~dok_s;
    end

endmodule
